ipif_master: RTL

Register-bus initiator that drives the IPIF responder side of the team's register-decoded blocks (clock monitors, parameter decoders) from a simple command/response stream. It converts one command at a time into IPIF chip-select and one-hot read/write chip-enable strobes, waits for the responder's acknowledge, and returns read data and error status. A watchdog terminates hung accesses with an error. It sits between a local controller (sequencer, test harness) and any IPIF-slave fabric, with no AXI bridge in between.

---
 rtl/ipif_master_pkg.sv | 18 +
 rtl/ipif_master_if.sv | 33 +++
 rtl/ipif_master_ce_decode.sv | 35 +++
 rtl/ipif_master.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ipif_master_pkg.sv
// Shared types and constants for the IPIF register-bus initiator.
// Imported by the initiator top level and its chip-enable decoder.
package ipif_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int REG_BYTE_STRIDE = 4;

    // Index ports stay at least one bit wide even when only one target exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ipif_master_if.sv
// IPIF bus bundle between the initiator (master) and a register-decoded responder (slave).
interface ipif_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_CS   = 1,
    parameter int N_REG  = 4
);
    logic                      IPIF_Bus2IP_resetn;
    logic [ADDR_W-1:0]         IPIF_Bus2IP_Addr;
    logic                      IPIF_Bus2IP_RNW;
    logic [DATA_W/8-1:0]       IPIF_Bus2IP_BE;
    logic [N_CS-1:0]           IPIF_Bus2IP_CS;
    logic [N_CS*N_REG-1:0]     IPIF_Bus2IP_RdCE;
    logic [N_CS*N_REG-1:0]     IPIF_Bus2IP_WrCE;
    logic [DATA_W-1:0]         IPIF_Bus2IP_Data;
    logic [DATA_W-1:0]         IPIF_IP2Bus_Data;
    logic                      IPIF_IP2Bus_WrAck;
    logic                      IPIF_IP2Bus_RdAck;
    logic                      IPIF_IP2Bus_Error;

    modport master (
        output IPIF_Bus2IP_resetn, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
               IPIF_Bus2IP_CS, IPIF_Bus2IP_RdCE, IPIF_Bus2IP_WrCE, IPIF_Bus2IP_Data,
        input  IPIF_IP2Bus_Data, IPIF_IP2Bus_WrAck, IPIF_IP2Bus_RdAck, IPIF_IP2Bus_Error
    );

    modport slave (
        input  IPIF_Bus2IP_resetn, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
               IPIF_Bus2IP_CS, IPIF_Bus2IP_RdCE, IPIF_Bus2IP_WrCE, IPIF_Bus2IP_Data,
        output IPIF_IP2Bus_Data, IPIF_IP2Bus_WrAck, IPIF_IP2Bus_RdAck, IPIF_IP2Bus_Error
    );

endinterface

// File: rtl/ipif_master_ce_decode.sv
// Combinational map from (chip select, register, direction) to one-hot CS/RdCE/WrCE.
// Out-of-range indices produce all-zero vectors and a cleared o_idx_ok.
module ipif_ce_decode
    import ipif_master_pkg::*;
#(
    parameter int N_CS  = 1,
    parameter int N_REG = 4,
    localparam int CS_W  = idx_width(N_CS),
    localparam int REG_W = idx_width(N_REG)
) (
    input  logic [CS_W-1:0]         i_cs_idx,
    input  logic [REG_W-1:0]        i_reg_idx,
    input  logic                    i_rnw,
    output logic                    o_idx_ok,
    output logic [N_CS-1:0]         o_cs,
    output logic [N_CS*N_REG-1:0]   o_rdce,
    output logic [N_CS*N_REG-1:0]   o_wrce
);

    always_comb begin
        o_idx_ok = (int'(i_cs_idx) < N_CS) && (int'(i_reg_idx) < N_REG);
        o_cs     = '0;
        o_rdce   = '0;
        o_wrce   = '0;
        for (int c = 0; c < N_CS; c++) begin
            o_cs[c] = o_idx_ok && (int'(i_cs_idx) == c);
        end
        // CE bits are laid out chip-select major: bit = cs*N_REG + reg.
        for (int i = 0; i < N_CS * N_REG; i++) begin
            o_rdce[i] = o_idx_ok &&  i_rnw && ((int'(i_cs_idx) * N_REG + int'(i_reg_idx)) == i);
            o_wrce[i] = o_idx_ok && !i_rnw && ((int'(i_cs_idx) * N_REG + int'(i_reg_idx)) == i);
        end
    end

endmodule

// File: rtl/ipif_master.sv
// IPIF register-bus initiator: one command at a time becomes a CS/CE strobe cycle,
// terminated by the responder acknowledge or by a watchdog, then returned as a response.
module ipif_master
    import ipif_master_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_CS               = 1,
    parameter int N_REG              = 4,
    parameter int TIMEOUT            = 16,
    localparam int CS_W  = idx_width(N_CS),
    localparam int REG_W = idx_width(N_REG)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [CS_W-1:0]                 cmd_cs_idx,
    input  logic [REG_W-1:0]                cmd_reg_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] cmd_be,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                            rsp_error,
    ipif_master_if.master                   ipif
);

    localparam int CE_W  = N_CS * N_REG;
    localparam int BE_W  = C_S_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                          r_state, w_next_state;

    logic                            r_cmd_ready, w_cmd_ready_nxt;
    logic                            r_rsp_valid, w_rsp_valid_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                            r_rsp_error, w_rsp_error_nxt;
    logic                            r_resetn;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic                            r_rnw, w_rnw_nxt;
    logic [BE_W-1:0]                 r_be, w_be_nxt;
    logic [N_CS-1:0]                 r_cs, w_cs_nxt;
    logic [CE_W-1:0]                 r_rdce, w_rdce_nxt;
    logic [CE_W-1:0]                 r_wrce, w_wrce_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_data, w_data_nxt;
    logic [CNT_W-1:0]                r_count, w_count_nxt;

    logic                            w_idx_ok;
    logic [N_CS-1:0]                 w_dec_cs;
    logic [CE_W-1:0]                 w_dec_rdce;
    logic [CE_W-1:0]                 w_dec_wrce;
    logic                            w_accept;
    logic                            w_ack;
    logic                            w_timeout;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   w_cmd_addr;

    ipif_ce_decode #(
        .N_CS  (N_CS),
        .N_REG (N_REG)
    ) u_ce_decode (
        .i_cs_idx  (cmd_cs_idx),
        .i_reg_idx (cmd_reg_idx),
        .i_rnw     (cmd_rnw),
        .o_idx_ok  (w_idx_ok),
        .o_cs      (w_dec_cs),
        .o_rdce    (w_dec_rdce),
        .o_wrce    (w_dec_wrce)
    );

    assign w_accept   = (r_state == IDLE) && r_cmd_ready && cmd_valid;
    // Only the acknowledge matching the latched direction terminates the access.
    assign w_ack      = r_rnw ? ipif.IPIF_IP2Bus_RdAck : ipif.IPIF_IP2Bus_WrAck;
    assign w_timeout  = (r_count == CNT_W'(TIMEOUT - 1));
    assign w_cmd_addr = C_S_AXI_ADDR_WIDTH'((int'(cmd_cs_idx) * N_REG + int'(cmd_reg_idx))
                                            * REG_BYTE_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_idx_ok ? ACCESS : RESP;
            ACCESS:  if (w_ack || w_timeout) w_next_state = RESP;
            RESP:    if (r_rsp_valid && rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Computes the next value of every registered output; strobes default low.
    always_comb begin
        w_cmd_ready_nxt = (w_next_state == IDLE);
        w_rsp_valid_nxt = (w_next_state == RESP);
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        w_addr_nxt      = r_addr;
        w_rnw_nxt       = r_rnw;
        w_be_nxt        = r_be;
        w_data_nxt      = r_data;
        w_cs_nxt        = '0;
        w_rdce_nxt      = '0;
        w_wrce_nxt      = '0;
        w_count_nxt     = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rsp_rdata_nxt = '0;
                    w_rsp_error_nxt = !w_idx_ok;
                    if (w_idx_ok) begin
                        w_cs_nxt   = w_dec_cs;
                        w_rdce_nxt = w_dec_rdce;
                        w_wrce_nxt = w_dec_wrce;
                        w_addr_nxt = w_cmd_addr;
                        w_rnw_nxt  = cmd_rnw;
                        w_be_nxt   = cmd_be;
                        w_data_nxt = cmd_wdata;
                    end
                end
            end
            ACCESS: begin
                if (w_ack) begin
                    w_rsp_error_nxt = ipif.IPIF_IP2Bus_Error;
                    w_rsp_rdata_nxt = (r_rnw && !ipif.IPIF_IP2Bus_Error) ?
                                      ipif.IPIF_IP2Bus_Data : '0;
                end else if (w_timeout) begin
                    w_rsp_error_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_cs_nxt    = r_cs;
                    w_rdce_nxt  = r_rdce;
                    w_wrce_nxt  = r_wrce;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        r_resetn <= !reset;
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_addr      <= '0;
            r_rnw       <= 1'b0;
            r_be        <= '0;
            r_cs        <= '0;
            r_rdce      <= '0;
            r_wrce      <= '0;
            r_data      <= '0;
            r_count     <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_addr      <= w_addr_nxt;
            r_rnw       <= w_rnw_nxt;
            r_be        <= w_be_nxt;
            r_cs        <= w_cs_nxt;
            r_rdce      <= w_rdce_nxt;
            r_wrce      <= w_wrce_nxt;
            r_data      <= w_data_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign cmd_ready               = r_cmd_ready;
    assign rsp_valid               = r_rsp_valid;
    assign rsp_rdata               = r_rsp_rdata;
    assign rsp_error               = r_rsp_error;
    assign ipif.IPIF_Bus2IP_resetn = r_resetn;
    assign ipif.IPIF_Bus2IP_Addr   = r_addr;
    assign ipif.IPIF_Bus2IP_RNW    = r_rnw;
    assign ipif.IPIF_Bus2IP_BE     = r_be;
    assign ipif.IPIF_Bus2IP_CS     = r_cs;
    assign ipif.IPIF_Bus2IP_RdCE   = r_rdce;
    assign ipif.IPIF_Bus2IP_WrCE   = r_wrce;
    assign ipif.IPIF_Bus2IP_Data   = r_data;

endmodule
